// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO pair.
// A start from EX runs a one-bit-per-cycle shift-add multiply or a restoring
// divide on operand magnitudes. A final FIX cycle applies the sign correction
// and commits HI/LO atomically. MDStall holds dependent HI/LO users in ID.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EXStart,
  input  logic [1:0]       EXOp,
  input  logic [WIDTH-1:0] EXRsData,
  input  logic [WIDTH-1:0] EXRtData,
  input  logic             EXMtHi,
  input  logic             EXMtLo,
  input  logic             IDUseHiLo,
  output logic             Busy,
  output logic             MDStall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_pend_q, dz_pend_d;    // divide started with a zero divisor
  logic [WIDTH-1:0] a_raw_q, a_raw_d;        // raw operand A, returned on divide-by-zero
  logic [WIDTH-1:0] opnd_q, opnd_d;          // |A| for multiply, |B| for divide
  logic [WIDTH:0]   acc_hi_q, acc_hi_d;      // product high half / remainder with guard bit
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;      // product low half / quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  // Operand magnitudes at issue; unsigned ops (EXOp[0] = 1) keep the raw values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~EXOp[0] & EXRsData[WIDTH-1];
  assign b_neg = ~EXOp[0] & EXRtData[WIDTH-1];
  assign a_mag = a_neg ? -EXRsData : EXRsData;
  assign b_mag = b_neg ? -EXRtData : EXRtData;

  // One multiply step: conditionally add |A| into the high half, then shift right.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q[WIDTH-1:0]} + {1'b0, mul_addend};

  // One restoring divide step: shift the next dividend bit in, trial-subtract.
  logic [WIDTH:0]   div_shift, div_diff;
  assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // Sign-corrected results presented during FIX.
  logic [2*WIDTH-1:0] mag_prod, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  assign mag_prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_res = (sign_a_q ^ sign_b_q) ? -mag_prod : mag_prod;
  assign quo_res  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
  assign rem_res  = sign_a_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  // Next-state and datapath update for the IDLE/RUN/FIX sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves a signal unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_pend_d  = dz_pend_q;
    a_raw_d    = a_raw_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (EXStart) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = EXOp[1];
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          dz_pend_d = EXOp[1] & (EXRtData == '0);
          a_raw_d   = EXRsData;
          acc_hi_d  = '0;
          if (EXOp[1]) begin
            opnd_d   = b_mag;
            acc_lo_d = a_mag;
          end else begin
            opnd_d   = a_mag;
            acc_lo_d = b_mag;
          end
        end else begin
          if (EXMtHi) hi_d = EXRsData;
          if (EXMtLo) lo_d = EXRsData;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d    = S_IDLE;
        div_zero_d = dz_pend_q;
        if (is_div_q) begin
          if (dz_pend_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_res;
            hi_d = rem_res;
          end
        end else begin
          {hi_d, lo_d} = prod_res;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation without a HI/LO write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_pend_q  <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_pend_q  <= dz_pend_d;
      a_raw_q    <= a_raw_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Busy    = (state_q != S_IDLE);
  // The EXStart term covers the issue cycle, before Busy has risen.
  assign MDStall = (Busy | EXStart) & IDUseHiLo;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign DivZero = div_zero_q;

endmodule
